// File: rtl/cevero_dvfs_pkg.sv
// Shared definitions for the DVFS control slice.
//   VW          - width of voltage level codes
//   RESET_LEVEL - level the regulator sits at out of reset (DVFS default)
//   vramp_state_e - ramp sequencer states
package cevero_dvfs_pkg;

    localparam int VW          = 3;
    localparam int RESET_LEVEL = 5;

    typedef enum logic [2:0] {
        IDLE,
        STALL,
        STEP,
        SETTLE,
        RELEASE
    } vramp_state_e;

endpackage

// File: rtl/cevero_cycle_timer.sv
// Loadable down-counter with a zero flag.
//   clk_i, rst_ni - clock, asynchronous active-low reset
//   load_i        - load load_val_i (takes priority over counting)
//   load_val_i    - value to load
//   en_i          - count down by one per cycle, saturating at zero
//   zero_o        - counter is zero
module cevero_cycle_timer #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/cevero_volt_ramp.sv
// Voltage ramp sequencer between cevero_dvfs and the voltage regulator.
// Holds the core clock, walks the regulator one level at a time toward the
// (clamped, live) target with a req/ack handshake and a settle wait after
// each step, then releases the core.
//   clk_i, rst_ni       - clock, asynchronous active-low reset
//   target_voltage_i    - requested level
//   stall_req_o/_ack_i  - core clock hold handshake
//   vreg_req_o/_level_o - regulator step request and requested level
//   vreg_ack_i          - regulator accepted the step
//   level_o             - committed regulator level
//   busy_o              - sequencer not idle
//   done_o              - one-cycle pulse at the end of a ramp (or timeout)
//   timeout_err_o       - sticky: regulator failed to acknowledge in time
module cevero_volt_ramp #(
    parameter int VW            = cevero_dvfs_pkg::VW,
    parameter int RESET_LEVEL   = cevero_dvfs_pkg::RESET_LEVEL,
    parameter int MIN_LEVEL     = 0,
    parameter int MAX_LEVEL     = 7,
    parameter int SETTLE_CYCLES = 16,
    parameter int ACK_TIMEOUT   = 64
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic [VW-1:0] target_voltage_i,
    output logic          stall_req_o,
    input  logic          stall_ack_i,
    output logic          vreg_req_o,
    output logic [VW-1:0] vreg_req_level_o,
    input  logic          vreg_ack_i,
    output logic [VW-1:0] level_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          timeout_err_o
);

    import cevero_dvfs_pkg::*;

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int AW = $clog2(ACK_TIMEOUT + 1);

    vramp_state_e  state_q, state_d;
    logic [VW-1:0] level_q, req_level_q;
    logic [VW-1:0] tgt, step_level;
    logic          err_q;
    logic          enter_step, enter_settle, ack_timeout;
    logic          settle_zero, ack_zero;

    // Clamp in int so the bounds checks stay meaningful for any MIN/MAX.
    always_comb begin
        tgt = target_voltage_i;
        if (int'(target_voltage_i) < MIN_LEVEL) begin
            tgt = VW'(MIN_LEVEL);
        end else if (int'(target_voltage_i) > MAX_LEVEL) begin
            tgt = VW'(MAX_LEVEL);
        end
    end

    // Next level one step toward the target; holds if already there so a
    // target that moved back during STALL can never wrap the code.
    always_comb begin
        step_level = level_q;
        if (tgt > level_q) begin
            step_level = level_q + VW'(1);
        end else if (tgt < level_q) begin
            step_level = level_q - VW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        enter_step   = 1'b0;
        enter_settle = 1'b0;
        ack_timeout  = 1'b0;
        case (state_q)
            IDLE: begin
                if (tgt != level_q) begin
                    state_d = STALL;
                end
            end
            STALL: begin
                if (stall_ack_i) begin
                    state_d    = STEP;
                    enter_step = 1'b1;
                end
            end
            STEP: begin
                // An ack on the last allowed cycle still wins over the timeout.
                if (vreg_ack_i) begin
                    state_d      = SETTLE;
                    enter_settle = 1'b1;
                end else if (ack_zero) begin
                    state_d     = RELEASE;
                    ack_timeout = 1'b1;
                end
            end
            SETTLE: begin
                if (settle_zero) begin
                    if (tgt == level_q) begin
                        state_d = RELEASE;
                    end else begin
                        // Core is still held, so go straight to the next step.
                        state_d    = STEP;
                        enter_step = 1'b1;
                    end
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Timers are loaded with N-1 on entry so the state lasts exactly N cycles.
    cevero_cycle_timer #(.W(SW)) u_settle_timer (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (enter_settle),
        .load_val_i (SW'(SETTLE_CYCLES - 1)),
        .en_i       (state_q == SETTLE),
        .zero_o     (settle_zero)
    );

    cevero_cycle_timer #(.W(AW)) u_ack_timer (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .load_i     (enter_step),
        .load_val_i (AW'(ACK_TIMEOUT - 1)),
        .en_i       (state_q == STEP),
        .zero_o     (ack_zero)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            level_q     <= VW'(RESET_LEVEL);
            req_level_q <= VW'(RESET_LEVEL);
            err_q       <= 1'b0;
        end else begin
            // Direction is fixed at STEP entry and held for the whole STEP.
            if (enter_step) begin
                req_level_q <= step_level;
            end
            if (state_q == STEP && vreg_ack_i) begin
                level_q <= req_level_q;
            end
            if (ack_timeout) begin
                err_q <= 1'b1;
            end
        end
    end

    assign stall_req_o      = (state_q == STALL) || (state_q == STEP) || (state_q == SETTLE);
    assign vreg_req_o       = (state_q == STEP);
    assign vreg_req_level_o = req_level_q;
    assign level_o          = level_q;
    assign busy_o           = (state_q != IDLE);
    assign done_o           = (state_q == RELEASE);
    assign timeout_err_o    = err_q;

endmodule

// File: tb/tb_cevero_volt_ramp.sv
// Directed bench for cevero_volt_ramp with a protocol-level reference model.
module tb_cevero_volt_ramp;

    localparam int VW            = 3;
    localparam int RESET_LEVEL   = 5;
    localparam int MIN_LEVEL     = 0;
    localparam int MAX_LEVEL     = 7;
    localparam int SETTLE_CYCLES = 16;
    localparam int ACK_TIMEOUT   = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [VW-1:0] target = VW'(RESET_LEVEL);
    logic          stall_req, stall_ack, vreq, vack;
    logic [VW-1:0] req_level, level;
    logic          busy, done, err;
    logic          withhold = 1'b0;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int req_log[$];

    always #5 clk = ~clk;

    cevero_volt_ramp #(
        .VW(VW), .RESET_LEVEL(RESET_LEVEL), .MIN_LEVEL(MIN_LEVEL), .MAX_LEVEL(MAX_LEVEL),
        .SETTLE_CYCLES(SETTLE_CYCLES), .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .target_voltage_i (target),
        .stall_req_o      (stall_req),
        .stall_ack_i      (stall_ack),
        .vreg_req_o       (vreq),
        .vreg_req_level_o (req_level),
        .vreg_ack_i       (vack),
        .level_o          (level),
        .busy_o           (busy),
        .done_o           (done),
        .timeout_err_o    (err)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int clampl(input int t);
        if (t < MIN_LEVEL) return MIN_LEVEL;
        if (t > MAX_LEVEL) return MAX_LEVEL;
        return t;
    endfunction

    function automatic int toward(input int lvl, input int t);
        if (t > lvl) return lvl + 1;
        if (t < lvl) return lvl - 1;
        return lvl;
    endfunction

    // Issued request levels as decimal digits, e.g. requests 4 then 3 -> 43.
    function automatic int log_code();
        int r = 0;
        foreach (req_log[i]) r = r * 10 + req_log[i];
        return r;
    endfunction

    // Core and regulator: both answer one cycle after seeing a request.
    initial begin
        stall_ack = 1'b0;
        vack      = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            stall_ack = stall_req;
            vack      = vreq && !withhold;
        end
    end

    // Reference model, evaluated once per cycle on the falling edge.
    int m_level, m_err, pend, pend_val;
    int exp_stall, exp_quiet, exp_timeout, exp_settle_end;
    int in_settle, settle_cnt, step_run, prev_tgt, prev_vreq, prev_req, edone;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_level = RESET_LEVEL; m_err = 0; pend = 0; pend_val = 0;
                exp_stall = 0; exp_quiet = 0; exp_timeout = 0; exp_settle_end = 0;
                in_settle = 0; settle_cnt = 0; step_run = 0; prev_vreq = 0; prev_req = 0;
                prev_tgt = int'(target);
                chk("reset_outputs", int'({level, req_level, stall_req, vreq, busy, done, err}),
                    (RESET_LEVEL << 8) | (RESET_LEVEL << 5));
            end else begin
                if (pend != 0) begin
                    m_level = pend_val;
                    pend = 0;
                end
                edone = 0;
                if (exp_stall != 0) chk("idle_to_stall", int'(stall_req), 1);
                if (exp_quiet != 0) chk("stay_idle", int'(busy), 0);
                if (exp_timeout != 0) begin
                    chk("ack_timeout", int'({err, done, vreq}), 6);
                    m_err = 1;
                    edone = 1;
                end
                if (exp_settle_end != 0) begin
                    if (clampl(prev_tgt) == m_level) begin
                        edone = 1;
                    end else begin
                        chk("settle_to_step", int'(vreq), 1);
                    end
                end
                exp_stall = 0; exp_quiet = 0; exp_timeout = 0; exp_settle_end = 0;

                chk("done_pulse", int'(done), edone);
                chk("level", int'(level), m_level);
                chk("err_sticky", int'(err), m_err);
                chk("busy", int'(busy), int'(stall_req || done));
                if (vreq) chk("req_under_stall", int'(stall_req), 1);

                if (in_settle != 0) begin
                    chk("settle_hold", int'(stall_req && !vreq && !done), 1);
                    settle_cnt++;
                    if (settle_cnt == SETTLE_CYCLES) begin
                        in_settle = 0;
                        exp_settle_end = 1;
                    end
                end

                if (vreq) begin
                    if (prev_vreq == 0) begin
                        req_log.push_back(int'(req_level));
                        chk("step_dir", int'(req_level), toward(m_level, clampl(prev_tgt)));
                        step_run = 0;
                    end else begin
                        chk("req_stable", int'(req_level), prev_req);
                    end
                    if (vack) begin
                        pend = 1; pend_val = int'(req_level);
                        in_settle = 1; settle_cnt = 0;
                    end else begin
                        step_run++;
                        if (step_run == ACK_TIMEOUT) exp_timeout = 1;
                    end
                end

                if (done) exp_quiet = 1;
                if (!busy) begin
                    if (clampl(int'(target)) != m_level) exp_stall = 1;
                    else exp_quiet = 1;
                end
                if (done) done_cnt++;
                prev_tgt  = int'(target);
                prev_vreq = int'(vreq);
                prev_req  = int'(req_level);
            end
        end
    end

    task automatic ramp(input int t, input int max_cyc, output int bc);
        int fin = 0;
        bc = 0;
        @(posedge clk);
        #1 target = VW'(t);
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (busy) bc++;
            else if (bc > 0) begin fin = 1; break; end
        end
        chk("ramp_finished", fin, 1);
    endtask

    task automatic wait_level(input int v, input int max_cyc);
        int fin = 0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (int'(level) == v) begin fin = 1; break; end
        end
        chk("wait_level", fin, 1);
    endtask

    task automatic wait_idle(input int max_cyc);
        int fin = 0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            if (!busy) begin fin = 1; break; end
        end
        chk("wait_idle", fin, 1);
    endtask

    initial begin
        int bc, d0, steps, err_seen, fin, seen;

        repeat (3) @(negedge clk);
        chk("rst_level", int'(level), 5);
        chk("rst_req_level", int'(req_level), 5);
        #1 rst_n = 1'b1;

        // Target equals the reset level: nothing moves.
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (stall_req) seen = 1;
        end
        chk("idle_no_stall", seen, 0);
        chk("idle_level", int'(level), 5);
        chk("idle_busy", int'(busy), 0);

        // 5 -> 3: two down steps, 1+(1+16)*2+1 busy cycles.
        req_log.delete(); d0 = done_cnt;
        ramp(3, 200, bc);
        chk("t2_busy_cycles", bc, 36);
        chk("t2_level", int'(level), 3);
        chk("t2_log", log_code(), 43);
        chk("t2_dones", done_cnt - d0, 1);

        // 3 -> 7 with the regulator silent for 70 cycles.
        req_log.delete(); d0 = done_cnt; steps = 0; err_seen = 0; fin = 0;
        withhold = 1'b1;
        @(posedge clk);
        #1 target = 3'd7;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            if (i == 70) withhold = 1'b0;
            if (err && err_seen == 0) begin
                err_seen = 1;
                chk("t3_step_cycles", steps, 64);
                chk("t3_level_at_err", int'(level), 3);
                chk("t3_done_at_err", int'(done), 1);
                chk("t3_stall_at_err", int'(stall_req), 0);
            end else if (vreq && err_seen == 0) begin
                steps++;
            end
            if (err_seen != 0 && i > 70 && !busy) begin fin = 1; break; end
        end
        chk("t3_finished", fin, 1);
        chk("t3_level", int'(level), 7);
        chk("t3_err", int'(err), 1);
        chk("t3_log", log_code(), 44567);
        chk("t3_dones", done_cnt - d0, 2);

        // 5 -> 2, redirected to 6 during the first settle.
        ramp(5, 200, bc);
        req_log.delete(); d0 = done_cnt;
        @(posedge clk);
        #1 target = 3'd2;
        wait_level(4, 100);
        @(posedge clk);
        #1 target = 3'd6;
        wait_idle(200);
        chk("t4_level", int'(level), 6);
        chk("t4_log", log_code(), 456);
        chk("t4_dones", done_cnt - d0, 1);

        // 5 -> 7, trimmed to 6 while settling at 6.
        ramp(5, 200, bc);
        req_log.delete(); d0 = done_cnt;
        @(posedge clk);
        #1 target = 3'd7;
        wait_level(6, 100);
        @(posedge clk);
        #1 target = 3'd6;
        wait_idle(200);
        chk("t5_level", int'(level), 6);
        chk("t5_log", log_code(), 6);
        chk("t5_dones", done_cnt - d0, 1);

        // Reset while stepping from level 4.
        @(posedge clk);
        #1 target = 3'd2;
        fin = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (int'(level) == 4 && vreq) begin fin = 1; break; end
        end
        chk("t6_reached_step", fin, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_stall", int'(stall_req), 0);
        chk("t6_vreq", int'(vreq), 0);
        chk("t6_level", int'(level), 5);
        chk("t6_busy", int'(busy), 0);
        target = 3'd5;
        @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("t6_after_level", int'(level), 5);
        chk("t6_after_err", int'(err), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
